// File: rtl/uart_top.sv
// uart_top: full-duplex 8N1 UART, independent TX and RX FSMs with a 2-flop RX synchroniser.
// TX/RX strobes are one-cycle pulses; all outputs are registered.
module uart_top #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_uart_rxd,
    input  logic       i_tx_dv,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_done,
    output logic [7:0] o_rx_byte,
    output logic       o_uart_txd,
    output logic       o_rx_dv_led,
    output logic       o_tx_active_led
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_e;

    state_e          tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_idx_q, tx_idx_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            txd_q, txd_d;
    logic            tx_done_q, tx_done_d;
    logic            tx_active_q, tx_active_d;

    state_e          rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_idx_q, rx_idx_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            rx_dv_q, rx_dv_d;
    logic            rx_meta_q, rx_sync_q;

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_idx_d    = tx_idx_q;
        tx_data_d   = tx_data_q;
        txd_d       = txd_q;
        tx_done_d   = 1'b0;
        tx_active_d = tx_active_q;
        case (tx_state_q)
            IDLE: begin
                txd_d    = 1'b1;
                tx_cnt_d = '0;
                tx_idx_d = '0;
                if (i_tx_dv) begin
                    tx_data_d   = i_tx_byte;
                    txd_d       = 1'b0;
                    tx_active_d = 1'b1;
                    tx_state_d  = START;
                end
            end
            START: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    txd_d      = tx_data_q[0];
                    tx_state_d = DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = tx_idx_q + 3'd1;
                    txd_d      = (tx_idx_q == 3'd7) ? 1'b1 : tx_data_q[tx_idx_d];
                    tx_state_d = (tx_idx_q == 3'd7) ? STOP : DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d    = '0;
                    tx_done_d   = 1'b1;
                    tx_active_d = 1'b0;
                    tx_state_d  = CLEANUP;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    // Start is re-checked at mid-bit so a short low glitch never yields a byte
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_dv_d    = 1'b0;
        case (rx_state_q)
            IDLE: begin
                rx_cnt_d   = '0;
                rx_idx_d   = '0;
                rx_state_d = rx_sync_q ? IDLE : START;
            end
            START: begin
                if (rx_cnt_q == HALF) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_sync_q ? IDLE : DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (rx_cnt_q == LAST) begin
                    rx_cnt_d             = '0;
                    rx_shift_d[rx_idx_q] = rx_sync_q;
                    rx_idx_d             = rx_idx_q + 3'd1;
                    rx_state_d           = (rx_idx_q == 3'd7) ? STOP : DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (rx_cnt_q == LAST) begin
                    rx_cnt_d   = '0;
                    rx_byte_d  = rx_shift_q;
                    rx_dv_d    = 1'b1;
                    rx_state_d = CLEANUP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_state_q  <= IDLE;
            tx_cnt_q    <= '0;
            tx_idx_q    <= '0;
            tx_data_q   <= '0;
            txd_q       <= 1'b1;
            tx_done_q   <= 1'b0;
            tx_active_q <= 1'b0;
            rx_state_q  <= IDLE;
            rx_cnt_q    <= '0;
            rx_idx_q    <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            rx_dv_q     <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_idx_q    <= tx_idx_d;
            tx_data_q   <= tx_data_d;
            txd_q       <= txd_d;
            tx_done_q   <= tx_done_d;
            tx_active_q <= tx_active_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_idx_q    <= rx_idx_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_dv_q     <= rx_dv_d;
            rx_meta_q   <= i_uart_rxd;
            rx_sync_q   <= rx_meta_q;
        end
    end

    assign o_uart_txd      = txd_q;
    assign o_tx_done       = tx_done_q;
    assign o_tx_active_led = tx_active_q;
    assign o_rx_byte       = rx_byte_q;
    assign o_rx_dv_led     = rx_dv_q;
endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: table-driven and scoreboarded bench for uart_top.
module tb_uart_top;
    localparam int C = 87;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_uart_rxd = 1'b1;
    logic       i_tx_dv = 1'b0;
    logic [7:0] i_tx_byte = 8'h00;
    logic       o_tx_done, o_uart_txd, o_rx_dv_led, o_tx_active_led;
    logic [7:0] o_rx_byte;

    int checks = 0;
    int failures = 0;
    int tx_done_cnt = 0;
    int rx_dv_cnt = 0;
    int exp_tx = 0;
    int exp_rx = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    bit         dec_busy = 1'b0;
    int         dec_t = 0;
    logic [7:0] dec_byte = 8'h00;
    logic       dec_stop = 1'b0;

    typedef struct {
        bit         do_tx;
        logic [7:0] tx_byte;
        bit         do_rx;
        logic [7:0] rx_byte;
        logic [7:0] exp_rx_byte;
    } vec_t;
    vec_t vecs[5];

    uart_top #(.CLKS_PER_BIT(C)) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_uart_rxd(i_uart_rxd),
        .i_tx_dv(i_tx_dv),
        .i_tx_byte(i_tx_byte),
        .o_tx_done(o_tx_done),
        .o_rx_byte(o_rx_byte),
        .o_uart_txd(o_uart_txd),
        .o_rx_dv_led(o_rx_dv_led),
        .o_tx_active_led(o_tx_active_led)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line decoder plus scoreboard pop on each done / valid pulse
    initial forever begin
        @(negedge i_clk);
        if (!i_rst_n) begin
            dec_busy = 1'b0;
        end else begin
            if (dec_busy) begin
                dec_t++;
                if (dec_t % C == C / 2) begin
                    if (dec_t / C >= 1 && dec_t / C <= 8) dec_byte[dec_t / C - 1] = o_uart_txd;
                    else if (dec_t / C == 9) begin
                        dec_stop = o_uart_txd;
                        dec_busy = 1'b0;
                    end
                end
            end else if (!o_uart_txd) begin
                dec_busy = 1'b1;
                dec_t = 0;
            end
            if (o_tx_done) begin
                tx_done_cnt++;
                if (tx_q.size() == 0) check("tx_done_pending", 32'(tx_q.size()), 1);
                else begin
                    check("tx_line_byte", 32'(dec_byte), 32'(tx_q.pop_front()));
                    check("tx_stop_bit", 32'(dec_stop), 1);
                end
            end
            if (o_rx_dv_led) begin
                rx_dv_cnt++;
                if (rx_q.size() == 0) check("rx_dv_pending", 32'(rx_q.size()), 1);
                else check("rx_byte", 32'(o_rx_byte), 32'(rx_q.pop_front()));
            end
        end
    end

    task automatic tx_send(input logic [7:0] b);
        @(negedge i_clk);
        i_tx_dv = 1'b1;
        i_tx_byte = b;
        @(negedge i_clk);
        i_tx_dv = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        @(negedge i_clk);
        for (int i = 0; i < 10; i++) begin
            i_uart_rxd = f[i];
            repeat (C) @(negedge i_clk);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((tx_q.size() != 0 || rx_q.size() != 0) && n < 3000) begin
            @(negedge i_clk);
            n++;
        end
        check(name, 32'(tx_q.size() + rx_q.size()), 0);
        repeat (5) @(negedge i_clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_txd"}, 32'(o_uart_txd), 1);
        check({tag, "_tx_done"}, 32'(o_tx_done), 0);
        check({tag, "_rx_dv"}, 32'(o_rx_dv_led), 0);
        check({tag, "_tx_active"}, 32'(o_tx_active_led), 0);
        check({tag, "_rx_byte"}, 32'(o_rx_byte), 0);
    endtask

    initial begin
        logic [9:0] frame;
        int bad;
        logic exp_txd, exp_act, exp_done;
        vecs[0] = '{1'b1, 8'h00, 1'b1, 8'hFF, 8'hFF};
        vecs[1] = '{1'b1, 8'hC3, 1'b0, 8'h00, 8'hFF};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 8'h81, 8'h81};
        vecs[3] = '{1'b1, 8'h5A, 1'b1, 8'h0F, 8'h0F};
        vecs[4] = '{1'b1, 8'hFF, 1'b1, 8'h00, 8'h00};

        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset");
        i_rst_n = 1'b1;
        repeat (5) @(negedge i_clk);

        // TX 0xAB with exact bit timing, plus an ignored strobe mid-frame
        frame = {1'b1, 8'hAB, 1'b0};
        tx_q.push_back(8'hAB);
        exp_tx++;
        @(negedge i_clk);
        i_tx_dv = 1'b1;
        i_tx_byte = 8'hAB;
        bad = 0;
        for (int t = 0; t <= 10 * C + 1; t++) begin
            @(negedge i_clk);
            if (t == 300) begin
                i_tx_dv = 1'b1;
                i_tx_byte = 8'h55;
            end else i_tx_dv = 1'b0;
            exp_txd  = (t < 10 * C) ? frame[t / C] : 1'b1;
            exp_act  = (t < 10 * C);
            exp_done = (t == 10 * C);
            if (o_uart_txd !== exp_txd || o_tx_active_led !== exp_act || o_tx_done !== exp_done) begin
                bad++;
                if (bad <= 3) $display("FAIL tx_ab_cycle t=%0d: got txd=%b act=%b done=%b expected %b %b %b",
                                       t, o_uart_txd, o_tx_active_led, o_tx_done, exp_txd, exp_act, exp_done);
            end
        end
        check("tx_ab_waveform_bad_cycles", 32'(bad), 0);
        repeat (200) @(negedge i_clk);
        check("tx_ab_done_count", 32'(tx_done_cnt), 1);
        check("tx_busy_idle_line", 32'(o_uart_txd), 1);

        // RX 0x3F, byte held one clock after the stop bit ends
        rx_q.push_back(8'h3F);
        exp_rx++;
        rx_send(8'h3F);
        @(negedge i_clk);
        check("rx_3f_held", 32'(o_rx_byte), 32'h3F);
        check("rx_3f_dv_count", 32'(rx_dv_cnt), 1);

        // RX glitch: 20 clocks low must not produce a byte
        i_uart_rxd = 1'b0;
        repeat (20) @(negedge i_clk);
        i_uart_rxd = 1'b1;
        repeat (2 * C) @(negedge i_clk);
        check("rx_glitch_dv_count", 32'(rx_dv_cnt), 1);
        check("rx_glitch_byte", 32'(o_rx_byte), 32'h3F);

        // Table-driven full-duplex frames
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].do_tx) begin
                tx_q.push_back(vecs[v].tx_byte);
                exp_tx++;
            end
            if (vecs[v].do_rx) begin
                rx_q.push_back(vecs[v].rx_byte);
                exp_rx++;
            end
            fork
                begin if (vecs[v].do_tx) tx_send(vecs[v].tx_byte); end
                begin if (vecs[v].do_rx) rx_send(vecs[v].rx_byte); end
            join
            drain("vec_drain");
            check("vec_rx_byte", 32'(o_rx_byte), 32'(vecs[v].exp_rx_byte));
            check("vec_tx_done_total", 32'(tx_done_cnt), 32'(exp_tx));
        end

        // RX back-to-back frames with no idle gap
        rx_q.push_back(8'hA5);
        rx_q.push_back(8'h5A);
        exp_rx += 2;
        rx_send(8'hA5);
        rx_send(8'h5A);
        drain("b2b_drain");
        check("b2b_rx_byte", 32'(o_rx_byte), 32'h5A);
        check("b2b_rx_dv_total", 32'(rx_dv_cnt), 32'(exp_rx));

        // Reset mid-TX and mid-RX: aborted frames yield no pulses
        fork
            rx_send(8'h69);
            begin
                tx_send(8'h96);
                repeat (400) @(negedge i_clk);
                i_rst_n = 1'b0;
                #1;
                check_reset_outputs("midreset");
            end
        join
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3 * C) @(negedge i_clk);
        check("post_reset_tx_done_total", 32'(tx_done_cnt), 32'(exp_tx));
        check("post_reset_rx_dv_total", 32'(rx_dv_cnt), 32'(exp_rx));
        check("post_reset_txd", 32'(o_uart_txd), 1);

        tx_q.push_back(8'h3C);
        rx_q.push_back(8'hC5);
        exp_tx++;
        exp_rx++;
        fork
            tx_send(8'h3C);
            rx_send(8'hC5);
        join
        drain("post_reset_drain");
        check("post_reset_rx_byte", 32'(o_rx_byte), 32'hC5);
        check("final_tx_done_total", 32'(tx_done_cnt), 32'(exp_tx));
        check("final_rx_dv_total", 32'(rx_dv_cnt), 32'(exp_rx));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
